// File: rtl/responder_pkg.sv
// Shared types and helpers for the quiz-round arbiter.
package responder_pkg;

  localparam int         NUM_PLAYERS = 4;
  localparam logic [3:0] BCD_MAX     = 4'd9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ANSWER = 2'd2,
    DONE   = 2'd3
  } state_t;

  // One BCD digit +1, sticking at 9.
  function automatic logic [3:0] bcd_inc_sat(input logic [3:0] d);
    return (d >= BCD_MAX) ? BCD_MAX : d + 4'd1;
  endfunction

  // Round-robin pick: first requester found searching upward from ptr.
  function automatic logic [NUM_PLAYERS-1:0] rr_pick(input logic [NUM_PLAYERS-1:0] req,
                                                     input logic [1:0] ptr);
    logic [NUM_PLAYERS-1:0] g;
    logic [1:0]             idx;
    logic                   found;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  // One-hot to player number 1..4, 0 when nobody.
  function automatic logic [3:0] onehot_num(input logic [NUM_PLAYERS-1:0] oh);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < NUM_PLAYERS; k++)
      if (oh[k]) n = 4'(k + 1);
    return n;
  endfunction

endpackage

// File: rtl/bcd_countdown.sv
// Two-digit BCD down counter for the answer window; holds at 00.
module bcd_countdown
  import responder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_units,
  input  logic       tick,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       zero
);

  assign zero = (tens == 4'd0) && (units == 4'd0);

  // Clear beats load beats tick; a tick at 00 leaves the value alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (clear) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (load) begin
      tens  <= load_tens;
      units <= load_units;
    end else if (tick && !zero) begin
      if (units == 4'd0) begin
        units <= BCD_MAX;
        tens  <= tens - 4'd1;
      end else begin
        units <= units - 4'd1;
      end
    end
  end

endmodule

// File: rtl/quiz_round_arbiter.sv
// Quiz-round buzzer arbiter: synchronizes keys/start, grants one player
// round-robin, times the answer window and keeps four BCD scores.
module quiz_round_arbiter
  import responder_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int ANSWER_SEC = 30
) (
  input  logic        CLK,
  input  logic        Rst,
  input  logic        Start,
  input  logic [3:0]  Key_In,
  input  logic        Judge_Ok,
  input  logic        Judge_Fail,
  output logic [3:0]  Grant,
  output logic [3:0]  Player_Number,
  output logic [3:0]  TimerH,
  output logic [3:0]  TimerL,
  output logic        Buzzer_Req,
  output logic [3:0]  Foul,
  output logic [15:0] Score_Out,
  output logic        Timeout
);

  localparam int         PW     = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [3:0] TENS0  = 4'(ANSWER_SEC / 10);
  localparam logic [3:0] UNITS0 = 4'(ANSWER_SEC % 10);

  state_t state, state_n;

  logic [NUM_PLAYERS-1:0] key_s1, key_s2, key_s3;
  logic                   start_s1, start_s2;
  logic [NUM_PLAYERS-1:0] press;

  logic [NUM_PLAYERS-1:0]      grant, grant_n, foul, foul_n, mask, mask_n;
  logic [3:0]                  pn, pn_n;
  logic [1:0]                  ptr, ptr_n;
  logic [NUM_PLAYERS-1:0][3:0] score, score_n;
  logic                        timeout, timeout_n, buzz, buzz_n;
  logic                        go_idle, judge_ok, judge_fail;
  logic                        tmr_load, tmr_clear, tmr_zero, tmr_tick;
  logic [NUM_PLAYERS-1:0]      win;

  logic [PW-1:0] pre_cnt;
  logic          sec_tick;

  // Two sync flops plus one history flop; keys release to 1, Start to 0.
  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      key_s1   <= '1;
      key_s2   <= '1;
      key_s3   <= '1;
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
    end else begin
      key_s1   <= Key_In;
      key_s2   <= key_s1;
      key_s3   <= key_s2;
      start_s1 <= Start;
      start_s2 <= start_s1;
    end
  end

  // Active-low keys: a press is the synchronized 1->0 edge.
  assign press = key_s3 & ~key_s2;
  assign win   = rr_pick(press & ~foul & ~mask, ptr);

  assign sec_tick = (pre_cnt == PW'(CLK_FREQ - 1));
  // Only count down while staying in ANSWER so a judged or aborted round
  // freezes the display at the value it had.
  assign tmr_tick = sec_tick && (state == ANSWER) && (state_n == ANSWER);

  // 1 s prescaler, free-running only while the answer window is open.
  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst)                                     pre_cnt <= '0;
    else if (state != ANSWER || state_n != ANSWER) pre_cnt <= '0;
    else if (sec_tick)                           pre_cnt <= '0;
    else                                         pre_cnt <= pre_cnt + PW'(1);
  end

  bcd_countdown u_timer (
    .clk        (CLK),
    .rst        (Rst),
    .clear      (tmr_clear),
    .load       (tmr_load),
    .load_tens  (TENS0),
    .load_units (UNITS0),
    .tick       (tmr_tick),
    .tens       (TimerH),
    .units      (TimerL),
    .zero       (tmr_zero)
  );

  // State register.
  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state plus next values of all round bookkeeping.
  always_comb begin
    state_n    = state;
    grant_n    = grant;
    pn_n       = pn;
    foul_n     = foul;
    mask_n     = mask;
    score_n    = score;
    timeout_n  = timeout;
    ptr_n      = ptr;
    buzz_n     = 1'b0;
    tmr_load   = 1'b0;
    tmr_clear  = 1'b0;
    go_idle    = 1'b0;
    judge_ok   = Judge_Ok;
    judge_fail = Judge_Fail & ~Judge_Ok;

    case (state)
      IDLE: begin
        foul_n = foul | press;
        if (start_s2) state_n = ARMED;
      end
      ARMED: begin
        if (!start_s2) go_idle = 1'b1;
        else if (|win) begin
          grant_n  = win;
          pn_n     = onehot_num(win);
          // Player number is index+1, so its low bits are the next index mod 4.
          ptr_n    = pn_n[1:0];
          buzz_n   = 1'b1;
          tmr_load = 1'b1;
          state_n  = ANSWER;
        end
      end
      ANSWER: begin
        if (!start_s2) go_idle = 1'b1;
        else if (judge_ok) begin
          for (int i = 0; i < NUM_PLAYERS; i++)
            if (grant[i]) score_n[i] = bcd_inc_sat(score[i]);
          state_n = DONE;
        end else if (judge_fail) begin
          mask_n  = mask | grant;
          grant_n = '0;
          pn_n    = 4'd0;
          state_n = (&(mask_n | foul)) ? DONE : ARMED;
        end else if (sec_tick && tmr_zero) begin
          timeout_n = 1'b1;
          buzz_n    = 1'b1;
          state_n   = DONE;
        end
      end
      DONE: begin
        if (!start_s2) go_idle = 1'b1;
      end
      default: go_idle = 1'b1;
    endcase

    if (go_idle) begin
      state_n   = IDLE;
      grant_n   = '0;
      pn_n      = 4'd0;
      mask_n    = '0;
      foul_n    = '0;
      timeout_n = 1'b0;
      tmr_clear = 1'b1;
    end
  end

  // Round bookkeeping registers; scores and pointer survive a return to IDLE.
  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      grant   <= '0;
      pn      <= 4'd0;
      foul    <= '0;
      mask    <= '0;
      score   <= '0;
      timeout <= 1'b0;
      ptr     <= 2'd0;
      buzz    <= 1'b0;
    end else begin
      grant   <= grant_n;
      pn      <= pn_n;
      foul    <= foul_n;
      mask    <= mask_n;
      score   <= score_n;
      timeout <= timeout_n;
      ptr     <= ptr_n;
      buzz    <= buzz_n;
    end
  end

  assign Grant         = grant;
  assign Player_Number = pn;
  assign Foul          = foul;
  assign Score_Out     = score;
  assign Timeout       = timeout;
  assign Buzzer_Req    = buzz;

endmodule

// File: tb/tb_quiz_round_arbiter.sv
// Randomized bench for quiz_round_arbiter against a round-level model.
module tb_quiz_round_arbiter;

  localparam int CF = 10;
  localparam int AS = 3;

  logic        CLK = 1'b0;
  logic        Rst, Start, Judge_Ok, Judge_Fail;
  logic [3:0]  Key_In;
  logic [3:0]  Grant, Player_Number, TimerH, TimerL, Foul;
  logic        Buzzer_Req, Timeout;
  logic [15:0] Score_Out;

  quiz_round_arbiter #(.CLK_FREQ(CF), .ANSWER_SEC(AS)) dut (
    .CLK(CLK), .Rst(Rst), .Start(Start), .Key_In(Key_In),
    .Judge_Ok(Judge_Ok), .Judge_Fail(Judge_Fail),
    .Grant(Grant), .Player_Number(Player_Number),
    .TimerH(TimerH), .TimerL(TimerL), .Buzzer_Req(Buzzer_Req),
    .Foul(Foul), .Score_Out(Score_Out), .Timeout(Timeout)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- round-level model ----------------
  typedef enum int {M_IDLE, M_ARMED, M_ANS, M_DONE} mst_t;
  mst_t       m_st;
  int         m_score[4];
  logic [3:0] m_foul, m_mask;
  int         m_win;     // granted player index, -1 none
  int         m_ptr;     // where the next simultaneous search begins
  logic       m_to;
  int         g_cyc;     // cycle of the last grant

  function automatic logic [15:0] exp_score();
    logic [15:0] s;
    for (int i = 0; i < 4; i++) s[i*4 +: 4] = 4'(m_score[i]);
    return s;
  endfunction

  function automatic logic [3:0] exp_grant();
    return (m_win < 0) ? 4'd0 : 4'(1 << m_win);
  endfunction

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_foul = '0; m_mask = '0; m_win = -1; m_ptr = 0; m_to = 1'b0;
    for (int i = 0; i < 4; i++) m_score[i] = 0;
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk_round(input string tag);
    chk({tag, ".grant"}, Grant, exp_grant());
    chk({tag, ".pn"}, Player_Number, 4'(m_win + 1));
    chk({tag, ".foul"}, Foul, m_foul);
    chk({tag, ".score"}, Score_Out, exp_score());
    chk({tag, ".timeout"}, Timeout, m_to);
  endtask

  task automatic start_round();
    Start = 1'b1;
    tick_n(4);
    if (m_st == M_IDLE) m_st = M_ARMED;
    chk_round("start");
  endtask

  task automatic end_round();
    Start = 1'b0;
    tick_n(4);
    m_st = M_IDLE; m_win = -1; m_mask = '0; m_foul = '0; m_to = 1'b0;
    chk_round("idle");
    chk("idle.timer", {TimerH, TimerL}, 8'h00);
  endtask

  // Press the keys in p (1 = pressed), check the 3-cycle grant latency.
  task automatic press_keys(input logic [3:0] p);
    logic [3:0] elig;
    logic       granted;
    int         w;
    granted = 1'b0;
    Key_In = ~p;
    tick_n(2);
    chk("press.early_grant", Grant, exp_grant());
    chk("press.early_foul", Foul, m_foul);
    tick_n(1);
    if (m_st == M_IDLE) m_foul = m_foul | p;
    else if (m_st == M_ARMED) begin
      elig = p & ~m_foul & ~m_mask;
      w = -1;
      for (int k = 0; k < 4; k++)
        if (w < 0 && elig[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      if (w >= 0) begin
        m_win = w; m_ptr = (w + 1) % 4; m_st = M_ANS; granted = 1'b1; g_cyc = cyc;
      end
    end
    chk_round("press");
    chk("press.buzz", Buzzer_Req, granted);
    if (granted) chk("press.timer", {TimerH, TimerL}, bcd2(AS));
    tick_n(1);
    chk("press.buzz_end", Buzzer_Req, 1'b0);
    Key_In = 4'hF;
    tick_n(3);
  endtask

  task automatic judge(input logic ok, input logic fail);
    Judge_Ok = ok; Judge_Fail = fail;
    tick_n(1);
    Judge_Ok = 1'b0; Judge_Fail = 1'b0;
    if (m_st == M_ANS) begin
      if (ok) begin
        if (m_score[m_win] < 9) m_score[m_win]++;
        m_st = M_DONE;
      end else if (fail) begin
        m_mask[m_win] = 1'b1;
        m_win = -1;
        m_st = ((m_mask | m_foul) == 4'hF) ? M_DONE : M_ARMED;
      end
    end
    chk_round("judge");
    chk("judge.buzz", Buzzer_Req, 1'b0);
  endtask

  initial begin
    int e, left, r, tries;
    Rst = 1'b1; Start = 1'b0; Key_In = 4'hF; Judge_Ok = 1'b0; Judge_Fail = 1'b0;
    model_reset();
    tick_n(3);
    chk_round("reset");
    chk("reset.timer", {TimerH, TimerL}, 8'h00);
    chk("reset.buzz", Buzzer_Req, 1'b0);
    Rst = 1'b0;
    tick_n(2);

    // simultaneous presses 1 and 3, twice: pointer moves after each grant
    start_round(); press_keys(4'b0101); judge(1, 0); end_round();
    start_round(); press_keys(4'b0101); judge(1, 0); end_round();

    // single press of player 2, wrong answer, then presses ignored while masked
    start_round(); press_keys(4'b0010); judge(0, 1); press_keys(4'b0010); end_round();

    // false start by player 4, then player 4 ignored and player 2 granted
    press_keys(4'b1000);
    start_round(); press_keys(4'b1000); press_keys(4'b0010);
    press_keys(4'b0001);             // ignored during ANSWER
    judge(1, 1);                     // both judges count as correct
    end_round();

    // player 1 wrong, player 1 again ignored, player 3 granted and correct
    start_round(); press_keys(4'b0001); judge(0, 1); press_keys(4'b0001);
    press_keys(4'b0100); judge(1, 0); end_round();

    // timeout: window counts down at 10-cycle steps then expires
    start_round(); press_keys(4'b0010);
    while (cyc - g_cyc < 45) begin
      e = cyc - g_cyc;
      left = AS - e / CF;
      if (left < 0) left = 0;
      chk("to.timer", {TimerH, TimerL}, bcd2(left));
      chk("to.flag", Timeout, (e >= CF * (AS + 1)));
      chk("to.buzz", Buzzer_Req, (e == CF * (AS + 1)));
      tick_n(1);
    end
    m_st = M_DONE; m_to = 1'b1;
    judge(1, 0);                     // ignored in DONE
    chk("to.hold", {TimerH, TimerL}, 8'h00);
    end_round();

    // saturate player 4 at 9
    for (int n = 0; n < 10; n++) begin
      start_round(); press_keys(4'b1000); judge(1, 0); end_round();
    end

    // randomized rounds
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 3) == 0) press_keys(4'($urandom_range(1, 15)));
      start_round();
      tries = 0;
      while (m_st != M_DONE && tries < 4) begin
        press_keys(4'($urandom_range(1, 15)));
        if (m_st == M_ANS) begin
          r = $urandom_range(0, 2);
          judge(r != 1, r != 0);
        end
        tries++;
      end
      end_round();
    end

    // abort by dropping Start during ANSWER
    start_round(); press_keys(4'b0001);
    end_round();

    // asynchronous reset in the middle of ANSWER
    start_round(); press_keys(4'b0100);
    Rst = 1'b1;
    #1;
    model_reset();
    chk_round("arst");
    chk("arst.timer", {TimerH, TimerL}, 8'h00);
    chk("arst.buzz", Buzzer_Req, 1'b0);
    Start = 1'b0;
    tick_n(2);
    Rst = 1'b0;
    tick_n(3);
    start_round(); press_keys(4'b0101); judge(1, 0); end_round();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/quiz_round_arbiter.md
QUIZ_ROUND_ARBITER -- requirements
Module: quiz_round_arbiter

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, CLK cycles per 1 s tick.
REQ-002 Parameter ANSWER_SEC, default 30, answer window in seconds, legal range 1..99.
REQ-003 CLK  input  1  system clock; one clock; all state on rising edge.
REQ-004 Rst  input  1  reset, asynchronous, active-high.
REQ-005 Start  input  1  host round-enable level (SW1), asynchronous to CLK.
REQ-006 Key_In  input  4  player keys, active-low, already debounced, asynchronous.
REQ-007 Judge_Ok  input  1  host one-cycle pulse: granted answer correct.
REQ-008 Judge_Fail  input  1  host one-cycle pulse: granted answer wrong.
REQ-009 Grant  output  4  one-hot granted player, 0 = none.
REQ-010 Player_Number  output  4  binary 1..4 of granted player, 0 = none.
REQ-011 TimerH, TimerL  output  4 each  BCD tens/units of remaining answer time.
REQ-012 Buzzer_Req  output  1  one-cycle pulse on every grant and on timeout.
REQ-013 Foul  output  4  per-player false-start flags.
REQ-014 Score_Out  output  16  four BCD scores, player1 in [3:0].
REQ-015 Timeout  output  1  high in DONE when the round ended by time expiry.

Function
REQ-016 Start and Key_In SHALL each pass a 2-flop synchronizer; a press is a synchronized 1->0 edge, registered once more (3 CLK from stable low to press strobe).
REQ-017 States SHALL be IDLE, ARMED, ANSWER, DONE.
REQ-018 IDLE: press by player i SHALL set Foul[i]; synchronized Start high -> ARMED.
REQ-019 ARMED: eligible = pressed AND NOT Foul AND NOT Mask; any eligible press -> ANSWER on next edge, Grant/Player_Number updated that same edge, Buzzer_Req pulses that edge.
REQ-020 Simultaneous eligible presses SHALL resolve round-robin, search starting at index after last winner (pointer reset = player1); pointer advances only on grant.
REQ-021 Entering ANSWER SHALL load TimerH/TimerL with BCD of ANSWER_SEC and restart the 1 s prescaler at 0.
REQ-022 ANSWER: each tick decrements the BCD pair (units 0 borrows tens, units -> 9); presses ignored.
REQ-023 ANSWER + Judge_Ok: granted player's score +1 BCD, saturating at 9; -> DONE.
REQ-024 ANSWER + Judge_Fail: set Mask of granted player, clear Grant, -> ARMED; if all four players now Masked or Fouled -> DONE.
REQ-025 ANSWER, tick while TimerH/TimerL = 00: Timeout set, Buzzer_Req pulse, -> DONE; timer holds 00.
REQ-026 Judge_Ok and Judge_Fail together SHALL be treated as Judge_Ok; judges outside ANSWER ignored; a judge coinciding with the expiring tick wins over timeout.
REQ-027 DONE: Grant, Player_Number and timer value held for display; synchronized Start low -> IDLE.
REQ-028 Synchronized Start low in ARMED or ANSWER SHALL abort to IDLE next edge; no score change.
REQ-029 Transition to IDLE SHALL clear Grant, Player_Number, Mask, Foul, Timeout and set timer to 00; scores and pointer retained.
REQ-030 Prescaler SHALL run only in ANSWER.

Reset
REQ-031 Rst high SHALL force IDLE, Grant=0, Player_Number=0, TimerH=TimerL=0, Buzzer_Req=0, Foul=0, Mask=0, Score_Out=0, Timeout=0, pointer=player1, synchronizers to released (1 for keys, 0 for Start), immediately and asynchronously.
REQ-032 Rst mid-round SHALL discard the round entirely; first press after release is detected only from a new 1->0 edge.

Structure
REQ-033 Shared package responder_pkg SHALL hold the state encoding, player count 4 and BCD saturation value 9.
REQ-034 One sub-module bcd_countdown (load, tick, BCD pair out, zero flag) SHALL implement REQ-021/022/025 counting.

Verification (CLK_FREQ=10, ANSWER_SEC=3)
REQ-035 Start=1, Key_In=1101 -> Grant=0010, Player_Number=2, Buzzer_Req one pulse, TimerH/L=0/3, 3 CLK after press.
REQ-036 Keys 1 and 3 pressed same cycle, pointer=player1 -> Grant=0001; next round same stimulus -> Grant=0100.
REQ-037 Key 4 pressed while Start=0 -> Foul=1000; Start=1, Key 4 press ignored, Key 2 press -> Player_Number=2.
REQ-038 Grant player 1, Judge_Fail -> ARMED, player 1 press ignored, player 3 press granted; Judge_Ok -> Score_Out=0x0100.
REQ-039 Grant, no judge for 40 CLK -> timer 3,2,1,0 at 10-cycle steps, Timeout=1, Buzzer pulse; score 9 + Judge_Ok -> stays 9.
REQ-040 Rst pulse during ANSWER -> all outputs 0 same cycle; Start dropped during ANSWER -> IDLE, scores unchanged.
